// File: rtl/perm_pkg.sv
// Shared state encoding and sizing constants for the Ascon permutation sequencer.
package perm_pkg;
    localparam int STATE_W        = 320;
    localparam int MAX_ROUNDS     = 12;
    localparam int ROUND_W        = 5;
    localparam int TIMEOUT_CYCLES = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_WAIT,
        ST_RESP
    } seq_state_e;
endpackage

// File: rtl/perm_round_ctr.sv
// Round counter for the permutation core: holds the round limit, steps the
// counter on enable, and flags when the counter has reached the limit.
module perm_round_ctr
    import perm_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               load_i,
    input  logic               en_i,
    input  logic [ROUND_W-1:0] rounds_i,
    output logic [ROUND_W-1:0] ctr_o,
    output logic [ROUND_W-1:0] rounds_o,
    output logic               term_o
);
    logic [ROUND_W-1:0] ctr_q, ctr_d;
    logic [ROUND_W-1:0] lim_q, lim_d;

    assign term_o   = (ctr_q == lim_q);
    assign ctr_o    = ctr_q;
    assign rounds_o = lim_q;

    // Stepping stops at the limit, so the counter can never wrap.
    always_comb begin
        ctr_d = ctr_q;
        lim_d = lim_q;
        if (clr_i) begin
            ctr_d = '0;
            lim_d = '0;
        end else if (load_i) begin
            ctr_d = '0;
            lim_d = rounds_i;
        end else if (en_i && !term_o) begin
            ctr_d = ctr_q + ROUND_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctr_q <= '0;
            lim_q <= '0;
        end else begin
            ctr_q <= ctr_d;
            lim_q <= lim_d;
        end
    end
endmodule

// File: rtl/perm_sequencer.sv
// Initiator-side controller for the Ascon permutation core (load, rounds, wait, respond).
// Optional WAIT watchdog enabled by defining PERM_TIMEOUT_EN.
module perm_sequencer #(
    parameter int STATE_W    = perm_pkg::STATE_W,
    parameter int MAX_ROUNDS = perm_pkg::MAX_ROUNDS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [STATE_W-1:0]           req_state,
    input  logic [perm_pkg::ROUND_W-1:0] req_rounds,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [STATE_W-1:0]           rsp_state,
    output logic                         rsp_err,
    output logic                         busy,
    output logic [STATE_W-1:0]           perm_S,
    output logic [perm_pkg::ROUND_W-1:0] perm_ctr,
    output logic [perm_pkg::ROUND_W-1:0] perm_rounds,
    output logic                         perm_start,
    input  logic [STATE_W-1:0]           perm_out,
    input  logic                         perm_done
);
    import perm_pkg::*;

    localparam logic [ROUND_W-1:0] MAX_R = ROUND_W'(MAX_ROUNDS);

    seq_state_e         state_q;
    logic [STATE_W-1:0] s_q;
    logic [STATE_W-1:0] rsp_state_q;
    logic               rsp_valid_q;
    logic               rsp_err_q;
    logic               busy_q;
    logic               start_q;
    logic               legal;
    logic               ctr_clr, ctr_load, ctr_en, ctr_term;
`ifdef PERM_TIMEOUT_EN
    logic [2:0]         wd_q;
`endif

    assign legal       = (req_rounds != '0) && (req_rounds <= MAX_R);
    assign req_ready   = (state_q == ST_IDLE) && !rst;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_state   = rsp_state_q;
    assign rsp_err     = rsp_err_q;
    assign busy        = busy_q;
    assign perm_S      = s_q;
    assign perm_start  = start_q;

    always_comb begin
        ctr_clr  = 1'b0;
        ctr_load = 1'b0;
        ctr_en   = 1'b0;
        case (state_q)
            ST_IDLE: ctr_load = req_valid && legal;
            ST_LOAD: ctr_en   = 1'b1;
            ST_RUN:  ctr_en   = !ctr_term;
            ST_RESP: ctr_clr  = rsp_ready;
            default: ;
        endcase
    end

    perm_round_ctr u_round_ctr (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (ctr_clr),
        .load_i   (ctr_load),
        .en_i     (ctr_en),
        .rounds_i (req_rounds),
        .ctr_o    (perm_ctr),
        .rounds_o (perm_rounds),
        .term_o   (ctr_term)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            s_q         <= '0;
            rsp_state_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            start_q     <= 1'b0;
`ifdef PERM_TIMEOUT_EN
            wd_q        <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        busy_q <= 1'b1;
                        if (legal) begin
                            state_q <= ST_LOAD;
                            s_q     <= req_state;
                            start_q <= 1'b1;
                        end else begin
                            // Illegal round count: echo the input back, core untouched.
                            state_q     <= ST_RESP;
                            rsp_state_q <= req_state;
                            rsp_err_q   <= 1'b1;
                            rsp_valid_q <= 1'b1;
                        end
                    end
                end
                ST_LOAD: state_q <= ST_RUN;
                ST_RUN: begin
                    if (ctr_term) begin
                        state_q <= ST_WAIT;
                        start_q <= 1'b0;
`ifdef PERM_TIMEOUT_EN
                        wd_q    <= '0;
`endif
                    end
                end
                ST_WAIT: begin
                    if (perm_done) begin
                        state_q     <= ST_RESP;
                        rsp_state_q <= perm_out;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                    end
`ifdef PERM_TIMEOUT_EN
                    else if (wd_q == 3'(TIMEOUT_CYCLES - 1)) begin
                        state_q     <= ST_RESP;
                        rsp_state_q <= perm_out;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        wd_q <= wd_q + 3'd1;
                    end
`endif
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_perm_sequencer.sv
// Self-checking bench for perm_sequencer with a behavioural Ascon core model and
// a reference computed directly from the permutation definition.
module tb_perm_sequencer;
    localparam int SW = 320;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [SW-1:0] req_state = '0;
    logic [4:0]    req_rounds = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [SW-1:0] rsp_state;
    logic          rsp_err;
    logic          busy;
    logic [SW-1:0] perm_S;
    logic [4:0]    perm_ctr;
    logic [4:0]    perm_rounds;
    logic          perm_start;
    logic [SW-1:0] perm_out;
    logic          perm_done;

    int checks = 0;
    int errors = 0;
    bit withhold_done = 1'b0;

    always #5 clk = ~clk;

    perm_sequencer #(.STATE_W(SW), .MAX_ROUNDS(12)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_state(req_state), .req_rounds(req_rounds),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_state(rsp_state), .rsp_err(rsp_err), .busy(busy),
        .perm_S(perm_S), .perm_ctr(perm_ctr), .perm_rounds(perm_rounds),
        .perm_start(perm_start), .perm_out(perm_out), .perm_done(perm_done)
    );

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // One Ascon round with round-constant index i (0..11).
    function automatic logic [SW-1:0] ascon_round(input logic [SW-1:0] s, input int i);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        {x0, x1, x2, x3, x4} = s;
        x2 = x2 ^ 64'(((15 - i) << 4) | i);
        x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
        x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
        x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
        x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    function automatic logic [SW-1:0] ascon_p(input logic [SW-1:0] s, input int r);
        logic [SW-1:0] v;
        v = s;
        for (int k = 12 - r; k < 12; k++) v = ascon_round(v, k);
        return v;
    endfunction

    // Core model: load on ctr==0, one round per started cycle, done registered.
    logic [SW-1:0] core_q;
    logic          core_done_q;
    always @(posedge clk) begin
        if (rst) begin
            core_q      <= '0;
            core_done_q <= 1'b0;
        end else begin
            if (perm_start)
                core_q <= (perm_ctr == 5'd0) ? perm_S
                        : ascon_round(core_q, 12 - int'(perm_rounds) + int'(perm_ctr) - 1);
            core_done_q <= (perm_ctr == perm_rounds);
        end
    end
    assign perm_out  = core_q;
    assign perm_done = core_done_q & ~withhold_done;

    task automatic check(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [SW-1:0] rand_state();
        logic [SW-1:0] v;
        v = '0;
        for (int k = 0; k < 10; k++) v = {v[SW-33:0], 32'($urandom)};
        return v;
    endfunction

    task automatic do_req(input logic [SW-1:0] st, input int r, input int hold);
        logic [SW-1:0] exp_state;
        bit legal, exp_err;
        int lat, n;
        legal     = (r >= 1) && (r <= 12);
        exp_state = legal ? ascon_p(st, r) : st;
        exp_err   = !legal || withhold_done;
        lat       = !legal ? 1 : (withhold_done ? r + 6 : r + 3);
        check("req_ready_idle", req_ready, 1);
        req_valid  = 1'b1;
        req_state  = st;
        req_rounds = 5'(r);
        tick();
        req_valid = 1'b0;
        req_state = ~st;
        n = 1;
        while (!rsp_valid && n < 60) begin
            if (n == 1) begin
                check("load_S", perm_S, st);
                check("load_rounds", perm_rounds, SW'(r));
            end
            check("trace_start", perm_start, (n <= r + 1) ? 1 : 0);
            check("trace_ctr", perm_ctr, SW'((n <= r + 1) ? n - 1 : r));
            check("busy_run", busy, 1);
            tick();
            n++;
        end
        $display("req r=%0d hold=%0d latency=%0d err=%0b", r, hold, n, rsp_err);
        check("latency", SW'(n), SW'(lat));
        check("rsp_state", rsp_state, exp_state);
        check("rsp_err", rsp_err, exp_err);
        if (!legal) check("err_no_start", perm_start, 0);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", rsp_valid, 1);
            check("hold_state", rsp_state, exp_state);
            check("hold_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("post_rsp_valid", rsp_valid, 0);
        check("post_ctr", perm_ctr, 0);
        check("post_rounds", perm_rounds, 0);
        check("post_busy", busy, 0);
    endtask

    initial begin
        logic [SW-1:0] st;
        int n;
        rst = 1'b1;
        repeat (3) tick();
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_state", rsp_state, 0);
        check("rst_busy", busy, 0);
        check("rst_start", perm_start, 0);
        check("rst_ctr", perm_ctr, 0);
        check("rst_rounds", perm_rounds, 0);
        check("rst_S", perm_S, 0);
        rst = 1'b0;
        #1;
        check("rel_req_ready", req_ready, 1);
        tick();
        check("idle_done_high", perm_done, 1);
        repeat (20) begin
            tick();
            check("idle_no_rsp", rsp_valid, 0);
        end

        do_req(rand_state(), 12, 0);
        do_req(rand_state(), 6, 5);
        do_req(rand_state(), 1, 0);
        do_req(rand_state(), 0, 1);
        do_req(rand_state(), 13, 0);
        do_req(rand_state(), 31, 2);

        // Reset in the middle of RUN drops the transaction.
        st = rand_state();
        req_valid = 1'b1; req_state = st; req_rounds = 5'd10;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (perm_ctr != 5'd5 && n < 30) begin
            tick();
            n++;
        end
        check("mid_ctr5", perm_ctr, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_ctr", perm_ctr, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_start", perm_start, 0);
        check("mid_rst_valid", rsp_valid, 0);
        check("mid_rst_ready", req_ready, 1);
        repeat (15) begin
            tick();
            check("mid_no_rsp", rsp_valid, 0);
        end
        $display("reset mid-run at ctr=5 done");
        do_req(rand_state(), 8, 0);

        for (int k = 0; k < 10; k++)
            do_req(rand_state(), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));

`ifdef PERM_TIMEOUT_EN
        withhold_done = 1'b1;
        do_req(rand_state(), 3, 0);
        withhold_done = 1'b0;
        do_req(rand_state(), 4, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed no finish, required finish");
        $fatal(1, "bench timeout");
    end
endmodule

// File: doc/perm_sequencer.md
# perm_sequencer

Initiator-side controller for the Ascon permutation core. Accepts a 320-bit state and a round count over a valid/ready request channel and drives the core's `ctr`/`rounds`/`start`/`S` inputs through load and round cycles. Samples the core's `done`/`out` and returns the permuted state over a valid/ready response channel. Sits between the Ascon mode FSM (initialization, absorb, finalization) and the permutation core.

## Interface
Parameters:
- `STATE_W`, 320, permutation state width
- `MAX_ROUNDS`, 12, largest legal round count

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  sequencer can accept a request
- `req_state`  in  320  input state {x0..x4}, x0 in MSBs
- `req_rounds`  in  5  rounds to apply; legal range 1..MAX_ROUNDS
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  consumer accepts response
- `rsp_state`  out  320  permuted state, or unchanged input on error
- `rsp_err`  out  1  response is an error; qualified by rsp_valid
- `busy`  out  1  high in every state except IDLE
- `perm_S`  out  320  state to core, from captured request register
- `perm_ctr`  out  5  round counter to core
- `perm_rounds`  out  5  round count to core
- `perm_start`  out  1  core update enable
- `perm_out`  in  320  core state output
- `perm_done`  in  1  core done (registered in core: high the cycle after ctr==rounds)

## Operation
- States are IDLE, LOAD, RUN, WAIT and RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`: capture state and rounds.
  - Legal rounds: go to LOAD.
  - Rounds 0 or >MAX_ROUNDS: go to RESP with `rsp_state`=`req_state`, `rsp_err`=1. The core is not driven.
- **LOAD**: `perm_start`=1, `perm_ctr`=0, so the core loads `perm_S`. Next state is RUN with ctr=1.
- **RUN**
  - `perm_start`=1 and `perm_ctr` steps 1..r, one round per cycle.
  - When ctr==r, go to WAIT.
- **WAIT**
  - `perm_start`=0 and `perm_ctr` holds at r, so the core register holds.
  - When `perm_done`=1, capture `perm_out` into `rsp_state` with `rsp_err`=0, then go to RESP.
- **RESP**
  - `rsp_valid`=1; `rsp_state` and `rsp_err` are stable until `rsp_ready`.
  - On `rsp_valid`&`rsp_ready`, go to IDLE with ctr=0.
- `perm_done` is ignored outside WAIT. The core raises it whenever ctr==rounds, including ctr=rounds=0 in IDLE and after reset.
- `perm_rounds` holds the captured r from LOAD through RESP. It is 0 in IDLE.
- Counter is 5-bit unsigned and never wraps: it is bounded by MAX_ROUNDS and cleared on return to IDLE.

## Timing
- **Reset values:** state=IDLE, `req_ready`=0 while rst high and 1 the first cycle after, `rsp_valid`=0, `rsp_err`=0, `rsp_state`=0, `busy`=0, `perm_start`=0, `perm_ctr`=0, `perm_rounds`=0, `perm_S`=0.
- **Legal request accepted at edge T:**
  - LOAD in cycle T+1.
  - RUN in cycles T+2..T+1+r.
  - WAIT in T+2+r, where `perm_done` is already high.
  - `rsp_valid` rises at T+3+r. Latency is r+3 cycles.
- **Error request accepted at T:** `rsp_valid` at T+1.
- **Back-to-back requests:** the earliest next acceptance is the cycle after the response handshake, giving a throughput of one request per r+4 cycles with `rsp_ready` tied high.
- **Reset mid-operation:**
  - Any state returns to IDLE at the next edge; the transaction is dropped and no response is produced.
  - The core shares `rst` and clears with it.
- **Simultaneous reset and handshake:** rst wins and no handshake completes.

## Configuration
- `PERM_TIMEOUT_EN` defined:
  - A 3-bit watchdog counts cycles in WAIT.
  - If `perm_done` is not seen within 4 WAIT cycles, go to RESP with `rsp_err`=1 and `rsp_state`=`perm_out` as sampled.
- Undefined: WAIT waits indefinitely and the watchdog logic is absent.

## Structure
- Package `perm_pkg` holds:
  - the state encoding enum (IDLE, LOAD, RUN, WAIT, RESP);
  - `STATE_W`=320, `MAX_ROUNDS`=12 and `ROUND_W`=5;
  - the timeout limit constant (4).
- One sub-module, `perm_round_ctr`: a loadable 5-bit counter with clear, enable and terminal flag (ctr==r), driving `perm_ctr`.

## Test plan
- **Reset release:** after rst, check every output's reset value. Hold `perm_done`=1 from a model with ctr=rounds=0 and check there is no `rsp_valid` for 20 cycles.
- **Legal request, r=12, known state, `rsp_ready`=1:**
  - `perm_start`/`perm_ctr` sequence is 1/0, then 1/1..1/12, then 0/12.
  - `rsp_valid` rises 15 cycles after acceptance.
  - `rsp_state` matches the Ascon p12 golden vector and `rsp_err`=0.
- **Request r=6 with `rsp_ready` low for 5 cycles:** `rsp_state` is stable and `req_ready`=0 throughout; the next request is accepted the cycle after the handshake.
- **req_rounds=0 and req_rounds=13:** `rsp_valid` one cycle after acceptance, `rsp_err`=1, `rsp_state` equals the input, and `perm_start` never asserts.
- **rst asserted in RUN at ctr=5:** IDLE next cycle, `perm_ctr`=0, no response. A following r=8 request completes correctly.
- **With `PERM_TIMEOUT_EN`:** core model withholds `perm_done`; `rsp_err`=1 after 4 WAIT cycles.
